// File: rtl/mips_cpu_avalon_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter: m0 (CPU) and m1 (loader/DMA/debug) share one memory.
// Optional `ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise m0 has fixed priority.
module mips_cpu_avalon_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_waitrequest,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_waitrequest,

    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W/8-1:0] s_byteenable,
    output logic [DATA_W-1:0]   s_writedata,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_waitrequest,

    output logic [1:0]          grant
);

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OWN_M0 = 2'b01,
        OWN_M1 = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   last_owner_q, last_owner_d;   // 0 = m0, 1 = m1

    logic req0;
    logic req1;
    logic win_m1;

    assign req0  = m0_read | m0_write;
    assign req1  = m1_read | m1_write;
    assign grant = state_q;

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the master that did not own the bus last goes first.
    assign win_m1 = req1 & (~req0 | ~last_owner_q);
`else
    assign win_m1 = req1 & ~req0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    state_d = win_m1 ? OWN_M1 : OWN_M0;
                end
            end
            OWN_M0: begin
                // A request dropped before completion simply releases the bus.
                if (!req0) begin
                    state_d = IDLE;
                end else if (!s_waitrequest) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b0;
                end
            end
            OWN_M1: begin
                if (!req1) begin
                    state_d = IDLE;
                end else if (!s_waitrequest) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_byteenable   = '0;
        s_writedata    = '0;
        m0_readdata    = '0;
        m0_waitrequest = 1'b1;
        m1_readdata    = '0;
        m1_waitrequest = 1'b1;
        case (state_q)
            OWN_M0: begin
                s_address      = m0_address;
                s_read         = m0_read;
                s_write        = m0_write;
                s_byteenable   = m0_byteenable;
                s_writedata    = m0_writedata;
                m0_readdata    = s_readdata;
                m0_waitrequest = s_waitrequest;
            end
            OWN_M1: begin
                s_address      = m1_address;
                s_read         = m1_read;
                s_write        = m1_write;
                s_byteenable   = m1_byteenable;
                s_writedata    = m1_writedata;
                m1_readdata    = s_readdata;
                m1_waitrequest = s_waitrequest;
            end
            default: begin
            end
        endcase
    end

endmodule
